pc_stack: RTL

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pc_stack_if.sv | 34 +++
 rtl/pc_stack.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pc_stack_if.sv
// pc_stack_if: control/result bundle for pc_stack.
//   in    - jump or call target
//   load  - jump request, inc - sequential advance
//   call  - push return address and jump, ret - pop return address
//   out   - current program counter
//   level - number of valid stack entries
//   empty/full - level == 0 / level == DEPTH
//   err   - sticky stack-bounds error
// master drives the requests, slave (pc_stack) drives the results.
interface pc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    logic [WIDTH-1:0]         in;
    logic                     load;
    logic                     inc;
    logic                     call;
    logic                     ret;
    logic [WIDTH-1:0]         out;
    logic [$clog2(DEPTH):0]   level;
    logic                     empty;
    logic                     full;
    logic                     err;

    modport master (
        output in, load, inc, call, ret,
        input  out, level, empty, full, err
    );

    modport slave (
        input  in, load, inc, call, ret,
        output out, level, empty, full, err
    );
endinterface

// File: rtl/pc_stack.sv
// pc_stack: program counter with a circular return-address stack.
//   clk   - single clock, all state updates on its rising edge
//   reset - synchronous active-high reset
//   bus   - pc_stack_if.slave (in/load/inc/call/ret requests,
//           out/level/empty/full/err results, all registered)
// One action per cycle, priority reset > call > ret > load > inc > hold.
// Optional macro PC_STACK_BOUNDS_EN: reject call-when-full and
// ret-when-empty and raise a sticky err. Without it, overflow overwrites
// the oldest entry, underflow reads the stale entry, and err is 0.
module pc_stack #(
    parameter int               WIDTH        = 16,
    parameter int               DEPTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic       clk,
    input logic       reset,
    pc_stack_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Storage is deliberately not reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] out_q, out_d;
    logic [LW-1:0]    level_q, level_d;
    logic [PW-1:0]    ptr_q, ptr_d;      // points at the top-of-stack entry
    logic             empty_q, empty_d;
    logic             full_q, full_d;

    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] ret_addr;

`ifdef PC_STACK_BOUNDS_EN
    logic err_q, err_d;
`endif

    assign ret_addr = out_q + WIDTH'(1);

    always_comb begin
        out_d     = out_q;
        level_d   = level_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q + PW'(1);   // push always goes one above top
        mem_wdata = ret_addr;
`ifdef PC_STACK_BOUNDS_EN
        err_d     = err_q;
`endif
        if (bus.call) begin
            if (full_q) begin
`ifdef PC_STACK_BOUNDS_EN
                err_d = 1'b1;
`else
                // When full, the slot above top holds the oldest entry.
                mem_we = 1'b1;
                out_d  = bus.in;
                ptr_d  = ptr_q + PW'(1);
`endif
            end else begin
                mem_we  = 1'b1;
                out_d   = bus.in;
                ptr_d   = ptr_q + PW'(1);
                level_d = level_q + LW'(1);
            end
        end else if (bus.ret) begin
            if (empty_q) begin
`ifdef PC_STACK_BOUNDS_EN
                err_d = 1'b1;
`else
                out_d = mem_q[ptr_q];
                ptr_d = ptr_q - PW'(1);
`endif
            end else begin
                out_d   = mem_q[ptr_q];
                ptr_d   = ptr_q - PW'(1);
                level_d = level_q - LW'(1);
            end
        end else if (bus.load) begin
            out_d = bus.in;
        end else if (bus.inc) begin
            out_d = ret_addr;
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= RESET_VECTOR;
            level_q <= '0;
            ptr_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            level_q <= level_d;
            ptr_q   <= ptr_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // Reset suppresses the push so a call under reset leaves no trace.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifdef PC_STACK_BOUNDS_EN
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.out   = out_q;
    assign bus.level = level_q;
    assign bus.empty = empty_q;
    assign bus.full  = full_q;
endmodule
